// File: rtl/c7bbiu_pkg.sv
// Shared types and defaults for the c7b bus interface arbiter.
// Holds the FSM/owner encodings and the helper that turns a one-hot winner into an owner.
package c7bbiu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFU    = 2'd1,
    OWN_LSU_RD = 2'd2,
    OWN_LSU_WR = 2'd3
  } owner_t;

  localparam logic [7:0] DEF_TIMEOUT    = 8'd255;
  localparam logic [7:0] DEF_STARVE_MAX = 8'd4;

  // Bit positions inside the one-hot winner vector.
  localparam int WIN_IFU    = 0;
  localparam int WIN_LSU_RD = 1;
  localparam int WIN_LSU_WR = 2;

  function automatic owner_t owner_from_winner(input logic [2:0] winner);
    owner_t o;
    case (winner)
      3'b001:  o = OWN_IFU;
      3'b010:  o = OWN_LSU_RD;
      3'b100:  o = OWN_LSU_WR;
      default: o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/c7bbiu_prio.sv
// Combinational priority select: store > load > IFU, unless IFU has been starved.
module c7bbiu_prio
  import c7bbiu_pkg::*;
(
  input  logic       ifu_req,
  input  logic       lsu_rd_req,
  input  logic       lsu_wr_req,
  input  logic       starved,
  output logic [2:0] winner
);

  // Pick exactly one winner, or none when nobody requests.
  always_comb begin
    winner = 3'b000;
    if (starved && ifu_req) begin
      winner[WIN_IFU] = 1'b1;
    end else if (lsu_wr_req) begin
      winner[WIN_LSU_WR] = 1'b1;
    end else if (lsu_rd_req) begin
      winner[WIN_LSU_RD] = 1'b1;
    end else if (ifu_req) begin
      winner[WIN_IFU] = 1'b1;
    end else begin
      winner = 3'b000;
    end
  end

endmodule

// File: rtl/c7bbiu_arb.sv
// Bus interface arbiter: one outstanding transaction on the 64-bit SoC bus shared by
// IFU reads, LSU loads and LSU stores, with response routing, bus error and timeout.
module c7bbiu_arb
  import c7bbiu_pkg::*;
#(
  parameter logic [7:0] TIMEOUT    = DEF_TIMEOUT,
  parameter logic [7:0] STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_biu_rd_req,
  input  logic [31:0] ifu_biu_rd_addr,
  output logic        biu_ifu_rd_ack,
  output logic        biu_ifu_data_valid,
  output logic [63:0] biu_ifu_data,
  output logic        biu_ifu_buserr,
  input  logic        lsu_biu_rd_req_ls2,
  input  logic [31:0] lsu_biu_rd_addr_ls2,
  output logic        biu_lsu_rd_ack_ls2,
  output logic        biu_lsu_data_valid_ls3,
  output logic [63:0] biu_lsu_data_ls3,
  input  logic        lsu_biu_wr_req_ls2,
  input  logic [31:0] lsu_biu_wr_addr_ls2,
  input  logic [63:0] lsu_biu_wr_data_ls2,
  input  logic [7:0]  lsu_biu_wr_strb_ls2,
  output logic        biu_lsu_wr_ack_ls2,
  output logic        biu_lsu_wr_done_ls3,
  output logic        biu_lsu_buserr_ls3,
  output logic        biu_bus_req,
  output logic        biu_bus_we,
  output logic [31:0] biu_bus_addr,
  output logic [63:0] biu_bus_wdata,
  output logic [7:0]  biu_bus_strb,
  input  logic        bus_biu_gnt,
  input  logic        bus_biu_rvalid,
  input  logic [63:0] bus_biu_rdata,
  input  logic        bus_biu_wdone,
  input  logic        bus_biu_err
);

  state_t     state;
  state_t     next_state;
  owner_t     owner;
  logic [7:0] tcnt;
  logic [7:0] starve_cnt;
  logic [2:0] winner;
  logic       any_req;
  logic       start;
  logic       in_flight;
  logic       is_read;
  logic       is_write;
  logic       resp_done;
  logic       tmo_fire;
  logic       gnt_ok;
  logic       rd_ok;
  logic       wr_ok;
  logic       err_out;

  c7bbiu_prio u_prio (
    .ifu_req    (ifu_biu_rd_req),
    .lsu_rd_req (lsu_biu_rd_req_ls2),
    .lsu_wr_req (lsu_biu_wr_req_ls2),
    .starved    (starve_cnt == STARVE_MAX),
    .winner     (winner)
  );

  assign any_req   = ifu_biu_rd_req | lsu_biu_rd_req_ls2 | lsu_biu_wr_req_ls2;
  assign start     = (state == ST_IDLE) & any_req;
  assign in_flight = (state == ST_REQ) | (state == ST_WAIT);
  assign is_read   = (owner == OWN_IFU) | (owner == OWN_LSU_RD);
  assign is_write  = (owner == OWN_LSU_WR);

  // A completing response beats a coinciding timeout; mismatched strobes never complete.
  assign resp_done = (state == ST_WAIT) &
                     (bus_biu_err | (bus_biu_rvalid & is_read) | (bus_biu_wdone & is_write));
  assign tmo_fire  = in_flight & (tcnt == TIMEOUT) & ~resp_done;

  assign gnt_ok  = (state == ST_REQ) & bus_biu_gnt & ~tmo_fire;
  assign rd_ok   = (state == ST_WAIT) & bus_biu_rvalid & ~bus_biu_err;
  assign wr_ok   = (state == ST_WAIT) & bus_biu_wdone & ~bus_biu_err;
  assign err_out = ((state == ST_WAIT) & bus_biu_err) | tmo_fire;

  assign biu_ifu_data     = bus_biu_rdata;
  assign biu_lsu_data_ls3 = bus_biu_rdata;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (any_req) next_state = ST_REQ;
        else         next_state = ST_IDLE;
      end
      ST_REQ: begin
        if (tmo_fire)         next_state = ST_IDLE;
        else if (bus_biu_gnt) next_state = ST_WAIT;
        else                  next_state = ST_REQ;
      end
      ST_WAIT: begin
        if (resp_done || tmo_fire) next_state = ST_IDLE;
        else                       next_state = ST_WAIT;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Route accept and response pulses to the current owner only.
  always_comb begin
    biu_ifu_rd_ack         = 1'b0;
    biu_ifu_data_valid     = 1'b0;
    biu_ifu_buserr         = 1'b0;
    biu_lsu_rd_ack_ls2     = 1'b0;
    biu_lsu_data_valid_ls3 = 1'b0;
    biu_lsu_wr_ack_ls2     = 1'b0;
    biu_lsu_wr_done_ls3    = 1'b0;
    biu_lsu_buserr_ls3     = 1'b0;
    case (owner)
      OWN_IFU: begin
        biu_ifu_rd_ack     = gnt_ok;
        biu_ifu_data_valid = rd_ok;
        biu_ifu_buserr     = err_out;
      end
      OWN_LSU_RD: begin
        biu_lsu_rd_ack_ls2     = gnt_ok;
        biu_lsu_data_valid_ls3 = rd_ok;
        biu_lsu_buserr_ls3     = err_out;
      end
      OWN_LSU_WR: begin
        biu_lsu_wr_ack_ls2  = gnt_ok;
        biu_lsu_wr_done_ls3 = wr_ok;
        biu_lsu_buserr_ls3  = err_out;
      end
      default: begin
        biu_ifu_rd_ack = 1'b0;
      end
    endcase
  end

  // Transaction latches, bus request and timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner         <= OWN_NONE;
      tcnt          <= 8'd0;
      biu_bus_req   <= 1'b0;
      biu_bus_we    <= 1'b0;
      biu_bus_addr  <= 32'd0;
      biu_bus_wdata <= 64'd0;
      biu_bus_strb  <= 8'd0;
    end else begin
      biu_bus_req <= (next_state == ST_REQ);
      if (start) begin
        owner <= owner_from_winner(winner);
        if (winner[WIN_LSU_WR]) begin
          biu_bus_we    <= 1'b1;
          biu_bus_addr  <= lsu_biu_wr_addr_ls2;
          biu_bus_wdata <= lsu_biu_wr_data_ls2;
          biu_bus_strb  <= lsu_biu_wr_strb_ls2;
        end else if (winner[WIN_LSU_RD]) begin
          biu_bus_we    <= 1'b0;
          biu_bus_addr  <= lsu_biu_rd_addr_ls2;
          biu_bus_wdata <= 64'd0;
          biu_bus_strb  <= 8'hFF;
        end else begin
          biu_bus_we    <= 1'b0;
          biu_bus_addr  <= ifu_biu_rd_addr;
          biu_bus_wdata <= 64'd0;
          biu_bus_strb  <= 8'hFF;
        end
      end else if (next_state == ST_IDLE) begin
        owner <= OWN_NONE;
      end
      if (start)          tcnt <= 8'd0;
      else if (in_flight) tcnt <= tcnt + 8'd1;
      else                tcnt <= 8'd0;
    end
  end

  // IFU starvation counter: counts LSU wins while IFU waits, saturating at STARVE_MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 8'd0;
    end else if (start && winner[WIN_IFU]) begin
      starve_cnt <= 8'd0;
    end else if (!ifu_biu_rd_req) begin
      starve_cnt <= 8'd0;
    end else if (start && (starve_cnt < STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule

// File: doc/c7bbiu_arb.md
Name: c7bbiu_arb

Overview:
Bus interface arbiter. It shares the single external 64-bit memory bus port among three requesters: IFU instruction reads, LSU loads (LS2 read request) and LSU stores (LS2 write request). It allows one outstanding transaction at a time, routes the response back to the requester that owns it, and generates bus errors on bus error or timeout. It sits between the c7b core front ends and the SoC bus.

Parameters:
TIMEOUT, 255, cycles in REQ+WAIT before a transaction is aborted with buserr (1..255).
STARVE_MAX, 4, consecutive LSU grants allowed while IFU is pending before IFU is forced to win.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ifu_biu_rd_req  in  1  IFU read request; held until ack
ifu_biu_rd_addr  in  32  IFU read address
biu_ifu_rd_ack  out  1  one-cycle accept pulse to IFU
biu_ifu_data_valid  out  1  IFU read data valid pulse
biu_ifu_data  out  64  IFU read data
biu_ifu_buserr  out  1  IFU bus error pulse
lsu_biu_rd_req_ls2  in  1  LSU load request; held until ack
lsu_biu_rd_addr_ls2  in  32  LSU load address
biu_lsu_rd_ack_ls2  out  1  LSU load accept pulse
biu_lsu_data_valid_ls3  out  1  LSU load data valid pulse
biu_lsu_data_ls3  out  64  LSU load data
lsu_biu_wr_req_ls2  in  1  LSU store request; held until ack
lsu_biu_wr_addr_ls2  in  32  store address
lsu_biu_wr_data_ls2  in  64  store data
lsu_biu_wr_strb_ls2  in  8  byte strobes
biu_lsu_wr_ack_ls2  out  1  store accept pulse
biu_lsu_wr_done_ls3  out  1  store complete pulse
biu_lsu_buserr_ls3  out  1  LSU bus error pulse (load or store)
biu_bus_req  out  1  bus request (registered)
biu_bus_we  out  1  1=write (registered)
biu_bus_addr  out  32  latched address
biu_bus_wdata  out  64  latched write data
biu_bus_strb  out  8  latched strobes (0xFF for reads)
bus_biu_gnt  in  1  bus accepts request
bus_biu_rvalid  in  1  read data valid
bus_biu_rdata  in  64  read data
bus_biu_wdone  in  1  write complete
bus_biu_err  in  1  bus error response

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, owner=NONE, both counters=0. All outputs are 0, including biu_bus_addr, wdata and strb. An in-flight bus transaction is abandoned, and no ack or response is issued for it.
- States: IDLE, REQ, WAIT.
- IDLE: if any request is high, pick a winner and latch owner, we, addr, wdata and strb. Then go to REQ. biu_bus_req is high from the next cycle.
- Priority: LSU store > LSU load > IFU. IFU wins instead when starve_cnt==STARVE_MAX and ifu_biu_rd_req=1.
- starve_cnt: increments on each LSU grant while IFU is requesting. It clears on an IFU grant or when ifu_biu_rd_req=0. It saturates at STARVE_MAX.
- REQ: biu_bus_req=1. In the cycle bus_biu_gnt=1, the owner's ack is high combinationally (gnt & owner) and the state moves to WAIT. biu_bus_req is 0 from the next cycle. Exactly one ack pulse is issued per grant.
- WAIT: response strobes are passed through combinationally to the owner in the same cycle, then the state returns to IDLE.
  - Reads: rvalid drives data_valid.
  - Writes: wdone drives wr_done.
  - Error: err drives the owner's buserr.
- Data outputs are bus_biu_rdata, ungated. Their value is don't-care while valid is low.
- err together with rvalid or wdone in the same cycle: err wins and valid/done is suppressed.
- rvalid, wdone or err while in IDLE or REQ: ignored (protocol violation).
- Response strobe that does not match the transaction type (e.g. wdone on a read): ignored.
- Timeout counter (8 bits):
  - clears on entering REQ and increments every cycle in REQ or WAIT;
  - at TIMEOUT, with no completing event that cycle, pulse the owner's buserr, deassert biu_bus_req and go to IDLE;
  - a timeout in REQ also suppresses the ack.
- Back-to-back: the earliest next grant is the cycle after returning to IDLE. Minimum transaction spacing is 3 cycles plus bus latency.
- Requester contract: a requester holds its request and payload stable until ack, and drops the request in the cycle after ack. The arbiter never regrants a request it has already acked.

Decomposition:
- Shared package c7bbiu_pkg:
  - state encoding (IDLE, REQ, WAIT);
  - owner encoding (NONE, IFU, LSU_RD, LSU_WR);
  - default TIMEOUT and STARVE_MAX constants.
- One sub-module, c7bbiu_prio: combinational priority select with starvation override. Its inputs are the three requests and starve_cnt==STARVE_MAX; its output is a one-hot winner.
- The FSM, latches and counters stay in c7bbiu_arb.

Test Plan:
1. LSU load at 0x1004. gnt arrives 2 cycles after biu_bus_req, rvalid 3 cycles later with 0x123456789ABCDEF0 → one biu_lsu_rd_ack_ls2 pulse, then biu_lsu_data_valid_ls3 pulse with that data. IFU outputs stay 0.
2. LSU store to 0x2002, data 0xAA<<16, strb 0x04 → bus_we=1, addr 0x2002, strb 0x04. wr_ack on gnt, wr_done on wdone, state back to IDLE.
3. IFU and LSU load held continuously with STARVE_MAX=4 and the LSU re-requesting each time → the grant order is LSU×4, then IFU, with starve_cnt clearing after the IFU grant.
4. LSU load with bus_biu_err and rvalid in the same cycle → biu_lsu_buserr_ls3=1 and biu_lsu_data_valid_ls3=0.
5. IFU read with gnt but no response, TIMEOUT=8 → biu_ifu_buserr pulses 8 cycles after entry to REQ, then IDLE. A later LSU request is granted normally.
6. reset asserted in WAIT mid-read → all outputs 0 immediately. A late rvalid after reset release produces no data_valid.
